// File: rtl/alu_decoder.sv
// MIPS instruction decoder producing ALU control fields, with a two-entry
// (main + skid) output buffer on a valid/ready handshake.
module alu_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr_in,
    input  logic        Valid_in,
    output logic        Ready_out,
    output logic        Valid_out,
    input  logic        Ready_in,
    input  logic        Flush_in,
    output logic [5:0]  Func_out,
    output logic [4:0]  Rs_out,
    output logic [4:0]  Rt_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] Imm_out,
    output logic        AluSrcB_out,
    output logic        ShamtSel_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Illegal_out
);

    typedef struct packed {
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src_b;
        logic        shamt_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [5:0] FUNC_PASS_B = 6'b010000;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt_f;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign opcode   = Instr_in[31:26];
    assign rs_f     = Instr_in[25:21];
    assign rt_f     = Instr_in[20:16];
    assign rd_f     = Instr_in[15:11];
    assign shamt_f  = Instr_in[10:6];
    assign funct    = Instr_in[5:0];
    assign imm_sext = {{16{Instr_in[15]}}, Instr_in[15:0]};
    assign imm_zext = {16'h0000, Instr_in[15:0]};

    dec_t dec_d;

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        dec_d      = '0;
        dec_d.rs   = rs_f;
        dec_d.rt   = rt_f;
        dec_d.func = FUNC_PASS_B;
        unique case (opcode)
            6'b000000: begin
                unique case (funct)
                    6'b000000, 6'b000010, 6'b000011: begin
                        dec_d.func      = funct;
                        dec_d.imm       = {27'd0, shamt_f};
                        dec_d.shamt_sel = 1'b1;
                        dec_d.reg_write = 1'b1;
                        dec_d.rd        = rd_f;
                    end
                    6'b000100, 6'b000110, 6'b000111,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011: begin
                        dec_d.func      = funct;
                        dec_d.reg_write = 1'b1;
                        dec_d.rd        = rd_f;
                    end
                    6'b001000: begin
                        dec_d.func = 6'b111011;
                        dec_d.rd   = rd_f;
                    end
                    6'b001001: begin
                        dec_d.func      = 6'b111011;
                        dec_d.reg_write = 1'b1;
                        dec_d.rd        = rd_f;
                    end
                    default: dec_d.illegal = 1'b1;
                endcase
            end
            6'b000001: begin
                if (rt_f == 5'd0) begin
                    dec_d.func = 6'b111000;
                    dec_d.imm  = imm_sext;
                end else if (rt_f == 5'd1) begin
                    dec_d.func = 6'b111001;
                    dec_d.imm  = imm_sext;
                end else begin
                    dec_d.illegal = 1'b1;
                end
            end
            6'b000010: begin
                dec_d.func = 6'b111010;
                dec_d.imm  = {6'd0, Instr_in[25:0]};
            end
            6'b000011: begin
                dec_d.func      = 6'b111010;
                dec_d.imm       = {6'd0, Instr_in[25:0]};
                dec_d.reg_write = 1'b1;
                dec_d.rd        = 5'd31;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                // Branch codes 1111xx reuse the low opcode bits directly.
                dec_d.func = {4'b1111, opcode[1:0]};
                dec_d.imm  = imm_sext;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110: begin
                unique case (opcode[2:0])
                    3'b000:  dec_d.func = 6'b100000;
                    3'b001:  dec_d.func = 6'b100001;
                    3'b010:  dec_d.func = 6'b101010;
                    3'b011:  dec_d.func = 6'b101011;
                    3'b100:  dec_d.func = 6'b100100;
                    3'b101:  dec_d.func = 6'b100101;
                    default: dec_d.func = 6'b100110;
                endcase
                dec_d.imm       = opcode[2] ? imm_zext : imm_sext;
                dec_d.alu_src_b = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.rd        = rt_f;
            end
            6'b001111: begin
                dec_d.imm       = {Instr_in[15:0], 16'h0000};
                dec_d.alu_src_b = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.rd        = rt_f;
            end
            6'b100011: begin
                dec_d.func      = 6'b100000;
                dec_d.imm       = imm_sext;
                dec_d.alu_src_b = 1'b1;
                dec_d.reg_write = 1'b1;
                dec_d.mem_read  = 1'b1;
                dec_d.rd        = rt_f;
            end
            6'b101011: begin
                dec_d.func      = 6'b100000;
                dec_d.imm       = imm_sext;
                dec_d.alu_src_b = 1'b1;
                dec_d.mem_write = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    state_t state_q, state_d;
    dec_t   main_q, skid_q;
    logic   ready_q;
    logic   accept;
    logic   load_main;
    logic   load_skid;
    logic   move_skid;

    assign accept = Valid_in && ready_q;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (Flush_in) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && Ready_in) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (Ready_in) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (Ready_in) begin
                        state_d   = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state and payload update with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            // NOTE: payload registers are cleared only because the outputs
            // must read zero out of reset; a pure data buffer would not need it.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
            if (load_main) begin
                main_q <= dec_d;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_d;
            end
        end
    end

    assign Valid_out    = (state_q != EMPTY);
    assign Ready_out    = ready_q;
    assign Func_out     = main_q.func;
    assign Rs_out       = main_q.rs;
    assign Rt_out       = main_q.rt;
    assign Rd_out       = main_q.rd;
    assign Imm_out      = main_q.imm;
    assign AluSrcB_out  = main_q.alu_src_b;
    assign ShamtSel_out = main_q.shamt_sel;
    assign RegWrite_out = main_q.reg_write;
    assign MemRead_out  = main_q.mem_read;
    assign MemWrite_out = main_q.mem_write;
    assign Illegal_out  = main_q.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: decode table, streaming, backpressure,
// flush and mid-stream reset.
module tb_alu_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr_in;
    logic        Valid_in, Ready_out, Valid_out, Ready_in, Flush_in;
    logic [5:0]  Func_out;
    logic [4:0]  Rs_out, Rt_out, Rd_out;
    logic [31:0] Imm_out;
    logic        AluSrcB_out, ShamtSel_out, RegWrite_out;
    logic        MemRead_out, MemWrite_out, Illegal_out;
    logic [5:0]  flags_obs;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign flags_obs = {AluSrcB_out, ShamtSel_out, RegWrite_out,
                        MemRead_out, MemWrite_out, Illegal_out};

    always #5 clk = ~clk;

    alu_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Instr_in    (Instr_in),
        .Valid_in    (Valid_in),
        .Ready_out   (Ready_out),
        .Valid_out   (Valid_out),
        .Ready_in    (Ready_in),
        .Flush_in    (Flush_in),
        .Func_out    (Func_out),
        .Rs_out      (Rs_out),
        .Rt_out      (Rt_out),
        .Rd_out      (Rd_out),
        .Imm_out     (Imm_out),
        .AluSrcB_out (AluSrcB_out),
        .ShamtSel_out(ShamtSel_out),
        .RegWrite_out(RegWrite_out),
        .MemRead_out (MemRead_out),
        .MemWrite_out(MemWrite_out),
        .Illegal_out (Illegal_out)
    );

    // Flags order: {AluSrcB, ShamtSel, RegWrite, MemRead, MemWrite, Illegal}
    typedef struct {
        logic [31:0] instr;
        logic [5:0]  func;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  flags;
        bit          chk_imm;
        bit          chk_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Valid_in = 1'b0; Ready_in = 1'b1; Flush_in = 1'b0;
        Instr_in = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if (Valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", Valid_out);
        else pass_cnt++;
        total_cnt++;
        if (Ready_out !== 1'b1) $display("FAIL reset_ready got %b exp 1", Ready_out);
        else pass_cnt++;
        total_cnt++;
        if ({Func_out, Imm_out, Rd_out, flags_obs} !== '0)
            $display("FAIL reset_payload got func=%h imm=%h rd=%0d flags=%b exp all 0",
                     Func_out, Imm_out, Rd_out, flags_obs);
        else pass_cnt++;
    endtask

    task automatic test_decode_stream();
        vecs[0]  = '{32'h2128FFFC, 6'h20, 32'hFFFFFFFC, 5'd9, 5'd8,  5'd8,  6'b101000, 1'b1, 1'b1};
        vecs[1]  = '{32'h000B5100, 6'h00, 32'h00000004, 5'd0, 5'd11, 5'd10, 6'b011000, 1'b1, 1'b1};
        vecs[2]  = '{32'h35088000, 6'h25, 32'h00008000, 5'd8, 5'd8,  5'd8,  6'b101000, 1'b1, 1'b1};
        vecs[3]  = '{32'h3C081234, 6'h10, 32'h12340000, 5'd0, 5'd8,  5'd8,  6'b101000, 1'b1, 1'b1};
        vecs[4]  = '{32'h0C000010, 6'h3A, 32'h00000010, 5'd0, 5'd0,  5'd31, 6'b001000, 1'b1, 1'b1};
        vecs[5]  = '{32'hFC000000, 6'h10, 32'h00000000, 5'd0, 5'd0,  5'd0,  6'b000001, 1'b0, 1'b0};
        vecs[6]  = '{32'h8D09FFF0, 6'h20, 32'hFFFFFFF0, 5'd8, 5'd9,  5'd9,  6'b101100, 1'b1, 1'b1};
        vecs[7]  = '{32'hAD09000C, 6'h20, 32'h0000000C, 5'd8, 5'd9,  5'd0,  6'b100010, 1'b1, 1'b0};
        vecs[8]  = '{32'h1109FFFE, 6'h3C, 32'hFFFFFFFE, 5'd8, 5'd9,  5'd0,  6'b000000, 1'b1, 1'b0};
        vecs[9]  = '{32'h01000008, 6'h3B, 32'h00000000, 5'd8, 5'd0,  5'd0,  6'b000000, 1'b0, 1'b1};
        vecs[10] = '{32'h05010004, 6'h39, 32'h00000004, 5'd8, 5'd1,  5'd0,  6'b000000, 1'b1, 1'b0};
        vecs[11] = '{32'h012A4022, 6'h22, 32'h00000000, 5'd9, 5'd10, 5'd8,  6'b001000, 1'b0, 1'b1};
        vecs[12] = '{32'h00000001, 6'h10, 32'h00000000, 5'd0, 5'd0,  5'd0,  6'b000001, 1'b0, 1'b0};
        vecs[13] = '{32'h2D28FFFF, 6'h2B, 32'hFFFFFFFF, 5'd9, 5'd8,  5'd8,  6'b101000, 1'b1, 1'b1};
        Ready_in = 1'b1;
        Valid_in = 1'b1;
        // One word per cycle: each word must be on the outputs one cycle later.
        for (int i = 0; i < 14; i++) begin
            Instr_in = vecs[i].instr;
            tick();
            total_cnt++;
            if (Valid_out !== 1'b1 || Ready_out !== 1'b1)
                $display("FAIL dec%0d_hs got valid=%b ready=%b exp 1 1", i, Valid_out, Ready_out);
            else pass_cnt++;
            total_cnt++;
            if (Func_out !== vecs[i].func)
                $display("FAIL dec%0d_func got %b exp %b", i, Func_out, vecs[i].func);
            else pass_cnt++;
            total_cnt++;
            if (Rs_out !== vecs[i].rs || Rt_out !== vecs[i].rt)
                $display("FAIL dec%0d_rs_rt got %0d,%0d exp %0d,%0d", i, Rs_out, Rt_out,
                         vecs[i].rs, vecs[i].rt);
            else pass_cnt++;
            total_cnt++;
            if (flags_obs !== vecs[i].flags)
                $display("FAIL dec%0d_flags got %b exp %b", i, flags_obs, vecs[i].flags);
            else pass_cnt++;
            if (vecs[i].chk_rd) begin
                total_cnt++;
                if (Rd_out !== vecs[i].rd)
                    $display("FAIL dec%0d_rd got %0d exp %0d", i, Rd_out, vecs[i].rd);
                else pass_cnt++;
            end
            if (vecs[i].chk_imm) begin
                total_cnt++;
                if (Imm_out !== vecs[i].imm)
                    $display("FAIL dec%0d_imm got %h exp %h", i, Imm_out, vecs[i].imm);
                else pass_cnt++;
            end
        end
        Valid_in = 1'b0;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b0) $display("FAIL stream_drain got valid=%b exp 0", Valid_out);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        Ready_in = 1'b0;
        Valid_in = 1'b1;
        Instr_in = 32'h2128FFFC;               // A: addi
        tick();
        total_cnt++;
        if (Valid_out !== 1'b1 || Ready_out !== 1'b1 || Func_out !== 6'h20)
            $display("FAIL bp_first got valid=%b ready=%b func=%h exp 1 1 20",
                     Valid_out, Ready_out, Func_out);
        else pass_cnt++;
        Instr_in = 32'h35088000;               // B: ori, goes to skid
        tick();
        total_cnt++;
        if (Ready_out !== 1'b0) $display("FAIL bp_ready_drop got %b exp 0", Ready_out);
        else pass_cnt++;
        total_cnt++;
        if (Valid_out !== 1'b1 || Func_out !== 6'h20 || Imm_out !== 32'hFFFFFFFC || Rd_out !== 5'd8)
            $display("FAIL bp_hold1 got valid=%b func=%h imm=%h rd=%0d exp 1 20 fffffffc 8",
                     Valid_out, Func_out, Imm_out, Rd_out);
        else pass_cnt++;
        Instr_in = 32'h3C081234;               // C: lui, refused while full
        tick();
        total_cnt++;
        if (Ready_out !== 1'b0 || Valid_out !== 1'b1 || Func_out !== 6'h20 || Imm_out !== 32'hFFFFFFFC)
            $display("FAIL bp_hold2 got ready=%b valid=%b func=%h imm=%h exp 0 1 20 fffffffc",
                     Ready_out, Valid_out, Func_out, Imm_out);
        else pass_cnt++;
        Ready_in = 1'b1;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b1 || Func_out !== 6'h25 || Imm_out !== 32'h00008000 || Ready_out !== 1'b1)
            $display("FAIL bp_second got valid=%b func=%h imm=%h ready=%b exp 1 25 00008000 1",
                     Valid_out, Func_out, Imm_out, Ready_out);
        else pass_cnt++;
        tick();
        Valid_in = 1'b0;
        total_cnt++;
        if (Valid_out !== 1'b1 || Func_out !== 6'h10 || Imm_out !== 32'h12340000)
            $display("FAIL bp_third got valid=%b func=%h imm=%h exp 1 10 12340000",
                     Valid_out, Func_out, Imm_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b0) $display("FAIL bp_no_dup got valid=%b exp 0", Valid_out);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        Ready_in = 1'b0;
        Valid_in = 1'b1;
        Instr_in = 32'h2128FFFC;
        tick();
        Instr_in = 32'h35088000;
        tick();
        total_cnt++;
        if (Ready_out !== 1'b0) $display("FAIL flush_setup_two got ready=%b exp 0", Ready_out);
        else pass_cnt++;
        Instr_in = 32'h3C081234;
        Flush_in = 1'b1;
        tick();
        Flush_in = 1'b0;
        Valid_in = 1'b0;
        Ready_in = 1'b1;
        total_cnt++;
        if (Valid_out !== 1'b0 || Ready_out !== 1'b1)
            $display("FAIL flush_two got valid=%b ready=%b exp 0 1", Valid_out, Ready_out);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (Valid_out !== 1'b0) $display("FAIL flush_ghost%0d got valid=%b exp 0", i, Valid_out);
            else pass_cnt++;
        end
        // Flush in ONE while a new word is being accepted: it must be dropped too.
        Valid_in = 1'b1;
        Instr_in = 32'h0C000010;
        tick();
        Flush_in = 1'b1;
        Instr_in = 32'h2128FFFC;
        tick();
        Flush_in = 1'b0;
        Valid_in = 1'b0;
        total_cnt++;
        if (Valid_out !== 1'b0 || Ready_out !== 1'b1)
            $display("FAIL flush_one got valid=%b ready=%b exp 0 1", Valid_out, Ready_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b0) $display("FAIL flush_one_ghost got valid=%b exp 0", Valid_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        Ready_in = 1'b1;
        Valid_in = 1'b1;
        Instr_in = 32'h0C000010;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b1 || Rd_out !== 5'd31)
            $display("FAIL rst_mid_setup got valid=%b rd=%0d exp 1 31", Valid_out, Rd_out);
        else pass_cnt++;
        Ready_in = 1'b0;
        rst_n = 1'b0;
        Flush_in = 1'b1;
        Instr_in = 32'h8D09FFF0;
        tick();
        rst_n = 1'b1;
        Flush_in = 1'b0;
        Valid_in = 1'b0;
        total_cnt++;
        if (Valid_out !== 1'b0 || Ready_out !== 1'b1)
            $display("FAIL rst_mid_hs got valid=%b ready=%b exp 0 1", Valid_out, Ready_out);
        else pass_cnt++;
        total_cnt++;
        if ({Func_out, Rs_out, Rt_out, Rd_out, Imm_out, flags_obs} !== '0)
            $display("FAIL rst_mid_payload got func=%h rs=%0d rt=%0d rd=%0d imm=%h flags=%b exp all 0",
                     Func_out, Rs_out, Rt_out, Rd_out, Imm_out, flags_obs);
        else pass_cnt++;
        Ready_in = 1'b1;
        tick();
        total_cnt++;
        if (Valid_out !== 1'b0) $display("FAIL rst_mid_ghost got valid=%b exp 0", Valid_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_decode_stream();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
